fetch_inst_buffer: RTL and testbench

Instruction buffer between fetch stage 2 and decode. Each cycle it accepts the four predecoded instruction packets and per-lane valid bits from fetch stage 2, compacts the valid lanes in program order into a circular FIFO, and presents up to four of the oldest entries to decode. It back-pressures fetch with a full signal and is cleared on a pipeline flush.

---
 rtl/fetch_inst_buffer.sv | 128 ++++++++++++
 tb/tb_fetch_inst_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_buffer.sv
// Instruction buffer between fetch stage 2 and decode.
// Valid lanes of each incoming bundle are compacted in program order into a
// circular FIFO; the four oldest entries are presented to decode every cycle.
// Every output is decoded from registered state, so no input reaches an output
// without first passing through a flop.
module fetch_inst_buffer #(
    parameter int DEPTH = 16,
    parameter int PKT_W = 133
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       fs2Ready_i,
    input  logic [PKT_W-1:0]           inst0Packet_i,
    input  logic [PKT_W-1:0]           inst1Packet_i,
    input  logic [PKT_W-1:0]           inst2Packet_i,
    input  logic [PKT_W-1:0]           inst3Packet_i,
    input  logic                       inst0Valid_i,
    input  logic                       inst1Valid_i,
    input  logic                       inst2Valid_i,
    input  logic                       inst3Valid_i,
    input  logic                       decodeReady_i,
    output logic [PKT_W-1:0]           inst0Packet_o,
    output logic [PKT_W-1:0]           inst1Packet_o,
    output logic [PKT_W-1:0]           inst2Packet_o,
    output logic [PKT_W-1:0]           inst3Packet_o,
    output logic                       inst0Valid_o,
    output logic                       inst1Valid_o,
    output logic                       inst2Valid_o,
    output logic                       inst3Valid_o,
    output logic                       bufferFull_o,
    output logic [$clog2(DEPTH):0]     occupancy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PKT_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [PKT_W-1:0] pktIn [4];
    logic [3:0]       validIn;
    logic [PKT_W-1:0] pktOut [4];
    logic [PTR_W-1:0] laneOffset [4];
    logic [2:0]       nIn;
    logic [2:0]       nInEff;
    logic [2:0]       nOut;
    logic             bufferFull;
    logic             enq;

    assign pktIn[0] = inst0Packet_i;
    assign pktIn[1] = inst1Packet_i;
    assign pktIn[2] = inst2Packet_i;
    assign pktIn[3] = inst3Packet_i;
    assign validIn  = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};

    // Full uses the registered count only; the 4-entry headroom absorbs the
    // bundle fetch presents in the cycle before it sees the stall.
    assign bufferFull = count > CNT_W'(DEPTH - 4);
    assign enq        = fs2Ready_i & ~bufferFull & ~flush_i;
    assign nInEff     = enq ? nIn : 3'd0;

    // Each valid lane lands at tail plus the number of valid lanes older than it.
    always_comb begin
        nIn = 3'd0;
        for (int k = 0; k < 4; k++) begin
            laneOffset[k] = PTR_W'(nIn);
            nIn = nIn + 3'(validIn[k]);
        end
    end

    // Decode takes up to four entries, limited by what is buffered.
    always_comb begin
        nOut = 3'd0;
        if (decodeReady_i && !flush_i) begin
            nOut = (count >= CNT_W'(4)) ? 3'd4 : count[2:0];
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over enqueue and dequeue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(nOut);
            tail  <= tail + PTR_W'(nInEff);
            count <= count + CNT_W'(nInEff) - CNT_W'(nOut);
        end
    end

    // Packet storage is not reset; unoccupied entries are never presented as valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int k = 0; k < 4; k++) begin
                if (validIn[k]) begin
                    storage[tail + laneOffset[k]] <= pktIn[k];
                end
            end
        end
    end

    // Output lanes read head+0..head+3, wrapping through the pointer width.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pktOut[k] = storage[head + PTR_W'(k)];
        end
    end

    assign inst0Packet_o = pktOut[0];
    assign inst1Packet_o = pktOut[1];
    assign inst2Packet_o = pktOut[2];
    assign inst3Packet_o = pktOut[3];
    assign inst0Valid_o  = count > CNT_W'(0);
    assign inst1Valid_o  = count > CNT_W'(1);
    assign inst2Valid_o  = count > CNT_W'(2);
    assign inst3Valid_o  = count > CNT_W'(3);
    assign bufferFull_o  = bufferFull;
    assign occupancy_o   = count;

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Bench for fetch_inst_buffer: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_fetch_inst_buffer;

    localparam int DEPTH = 16;
    localparam int PKT_W = 133;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             fs2;
    logic             dec;
    logic [3:0]       mask;
    logic [PKT_W-1:0] pin [4];
    logic [PKT_W-1:0] pout [4];
    logic             vout [4];
    logic             full;
    logic [4:0]       occ;

    int checks = 0;
    int failures = 0;

    logic [PKT_W-1:0] mq [$];

    typedef struct {
        bit         fs2;
        logic [3:0] mask;
        logic [7:0] base;
        bit         dec;
        bit         flush;
        int         expOcc;
        bit         expFull;
        logic [31:0] expTags;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    fetch_inst_buffer #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
        .clk(clk),
        .reset(reset),
        .flush_i(flush),
        .fs2Ready_i(fs2),
        .inst0Packet_i(pin[0]),
        .inst1Packet_i(pin[1]),
        .inst2Packet_i(pin[2]),
        .inst3Packet_i(pin[3]),
        .inst0Valid_i(mask[0]),
        .inst1Valid_i(mask[1]),
        .inst2Valid_i(mask[2]),
        .inst3Valid_i(mask[3]),
        .decodeReady_i(dec),
        .inst0Packet_o(pout[0]),
        .inst1Packet_o(pout[1]),
        .inst2Packet_o(pout[2]),
        .inst3Packet_o(pout[3]),
        .inst0Valid_o(vout[0]),
        .inst1Valid_o(vout[1]),
        .inst2Valid_o(vout[2]),
        .inst3Valid_o(vout[3]),
        .bufferFull_o(full),
        .occupancy_o(occ)
    );

    function automatic logic [PKT_W-1:0] mkPkt(input logic [7:0] tag);
        return {tag[4:0], {16{tag}}};
    endfunction

    task automatic chk(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setIn(input bit f, input logic [3:0] m, input logic [7:0] base,
                         input bit d, input bit fl);
        fs2 = f;
        mask = m;
        dec = d;
        flush = fl;
        for (int k = 0; k < 4; k++) pin[k] = mkPkt(base + 8'(k));
    endtask

    task automatic compareModel();
        int sz;
        sz = mq.size();
        chk("model_occ", PKT_W'(occ), PKT_W'(sz));
        chk("model_full", PKT_W'(full), PKT_W'(sz > DEPTH - 4));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("model_valid%0d", k), PKT_W'(vout[k]), PKT_W'(sz > k));
            if (sz > k) chk($sformatf("model_pkt%0d", k), pout[k], mq[k]);
        end
    endtask

    // Reference model: a plain queue of packets, oldest first.
    task automatic step();
        int nOut;
        bit wasFull;
        @(posedge clk);
        wasFull = mq.size() > DEPTH - 4;
        if (flush) begin
            mq.delete();
        end else begin
            nOut = dec ? ((mq.size() < 4) ? mq.size() : 4) : 0;
            repeat (nOut) void'(mq.pop_front());
            if (fs2 && !wasFull) begin
                for (int k = 0; k < 4; k++) if (mask[k]) mq.push_back(pin[k]);
            end
        end
        #1;
        compareModel();
    endtask

    task automatic addVec(input bit f, input logic [3:0] m, input logic [7:0] base, input bit d,
                          input bit fl, input int eo, input bit ef, input logic [31:0] tags);
        vec_t v;
        v.fs2 = f; v.mask = m; v.base = base; v.dec = d; v.flush = fl;
        v.expOcc = eo; v.expFull = ef; v.expTags = tags;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] tag;
        reset = 1'b0;
        setIn(0, 4'h0, 8'h00, 0, 0);

        addVec(1, 4'hF,    8'hA0, 0, 0, 4,  0, 32'hA3A2A1A0);
        addVec(0, 4'h0,    8'h00, 1, 0, 0,  0, 32'h0);
        addVec(1, 4'b1101, 8'hB0, 0, 0, 3,  0, 32'h00B3B2B0);
        addVec(1, 4'hF,    8'hC0, 0, 0, 7,  0, 32'hC0B3B2B0);
        addVec(1, 4'hF,    8'hD0, 1, 0, 7,  0, 32'hD0C3C2C1);
        addVec(1, 4'hF,    8'h70, 1, 1, 0,  0, 32'h0);
        addVec(1, 4'hF,    8'hE0, 0, 0, 4,  0, 32'hE3E2E1E0);
        addVec(1, 4'hF,    8'h10, 0, 0, 8,  0, 32'hE3E2E1E0);
        addVec(1, 4'hF,    8'h20, 0, 0, 12, 0, 32'hE3E2E1E0);
        addVec(1, 4'hF,    8'h30, 0, 0, 16, 1, 32'hE3E2E1E0);
        addVec(1, 4'hF,    8'h40, 0, 0, 16, 1, 32'hE3E2E1E0);
        addVec(1, 4'hF,    8'h50, 1, 0, 12, 0, 32'h13121110);
        addVec(1, 4'hF,    8'h60, 0, 0, 16, 1, 32'h13121110);
        addVec(0, 4'h0,    8'h00, 0, 1, 0,  0, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_occ", PKT_W'(occ), '0);
        chk("reset_full", PKT_W'(full), '0);
        for (int k = 0; k < 4; k++) chk($sformatf("reset_valid%0d", k), PKT_W'(vout[k]), '0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            setIn(vecs[i].fs2, vecs[i].mask, vecs[i].base, vecs[i].dec, vecs[i].flush);
            step();
            chk($sformatf("vec%0d_occ", i), PKT_W'(occ), PKT_W'(vecs[i].expOcc));
            chk($sformatf("vec%0d_full", i), PKT_W'(full), PKT_W'(vecs[i].expFull));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("vec%0d_valid%0d", i, k), PKT_W'(vout[k]), PKT_W'(vecs[i].expOcc > k));
                if (vecs[i].expOcc > k) begin
                    tag = vecs[i].expTags[8*k +: 8];
                    chk($sformatf("vec%0d_pkt%0d", i, k), pout[k], mkPkt(tag));
                end
            end
        end

        // Wrap: bring head to 14 with two entries, then enqueue across the boundary.
        setIn(1, 4'hF, 8'h80, 0, 0); step();
        setIn(1, 4'hF, 8'h84, 0, 0); step();
        setIn(1, 4'hF, 8'h88, 0, 0); step();
        setIn(1, 4'b0011, 8'h8C, 0, 0); step();
        repeat (3) begin
            setIn(0, 4'h0, 8'h00, 1, 0); step();
        end
        setIn(1, 4'b0011, 8'h90, 1, 0); step();
        chk("wrap_pre_occ", PKT_W'(occ), PKT_W'(2));
        chk("wrap_pre_pkt0", pout[0], mkPkt(8'h90));
        setIn(1, 4'hF, 8'hA4, 0, 0); step();
        chk("wrap_occ", PKT_W'(occ), PKT_W'(6));
        chk("wrap_pkt1", pout[1], mkPkt(8'h91));
        chk("wrap_pkt2", pout[2], mkPkt(8'hA4));
        chk("wrap_pkt3", pout[3], mkPkt(8'hA5));
        setIn(1, 4'hF, 8'hB8, 1, 0); step();
        chk("wrap_deq_pkt0", pout[0], mkPkt(8'hA6));
        chk("wrap_deq_pkt2", pout[2], mkPkt(8'hB8));

        // Asynchronous reset between edges with nine entries buffered.
        setIn(0, 4'h0, 8'h00, 0, 1); step();
        setIn(1, 4'hF, 8'hC0, 0, 0); step();
        setIn(1, 4'hF, 8'hC4, 0, 0); step();
        setIn(1, 4'b0001, 8'hC8, 0, 0); step();
        chk("pre_areset_occ", PKT_W'(occ), PKT_W'(9));
        setIn(1, 4'hF, 8'hCC, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        chk("areset_occ", PKT_W'(occ), '0);
        chk("areset_full", PKT_W'(full), '0);
        for (int k = 0; k < 4; k++) chk($sformatf("areset_valid%0d", k), PKT_W'(vout[k]), '0);
        @(posedge clk);
        #1;
        chk("areset_hold_occ", PKT_W'(occ), '0);
        @(negedge clk);
        reset = 1'b1;
        setIn(1, 4'hF, 8'hD0, 0, 0); step();
        chk("after_areset_occ", PKT_W'(occ), PKT_W'(4));
        chk("after_areset_pkt0", pout[0], mkPkt(8'hD0));

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            fs2 = ($urandom_range(3) != 0);
            dec = ($urandom_range(1) != 0);
            flush = ($urandom_range(31) == 0);
            mask = 4'($urandom);
            for (int k = 0; k < 4; k++)
                pin[k] = {5'($urandom), $urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
